r2sdf_stage_ctrl: RTL and testbench
===================================

Name: r2sdf_stage_ctrl

Overview:
- Sequencing controller for one radix-2 single-path delay-feedback (R2SDF) FFT stage.
- Drives the write/read strobes of the stage's first-word-fall-through delay FIFO pair (real and imaginary) and the butterfly select.
- Generates the twiddle ROM address, output-valid and frame markers.
- Detects FIFO misuse and supports an end-of-stream flush.

Parameters:
- DELAY, 512, stage delay-line length (half the stage span); power of two, ≥2.
- ADDR_W, 9, counter and twiddle-address width; equals log2(DELAY).
- TW_STEP, 1, twiddle address increment per butterfly sample; stage-dependent stride.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- areset  in  1  synchronous active-high reset.
- in_valid  in  1  input sample present this cycle.
- flush  in  1  single-cycle pulse; drain the delay line after the last input.
- fifo_full  in  1  OR of the real and imaginary FIFO full flags.
- fifo_empty  in  1  OR of the real and imaginary FIFO empty flags.
- fifo_wr  out  1  FIFO write strobe (both halves).
- fifo_rd  out  1  FIFO read/advance strobe (both halves).
- bf_sel  out  1  0 = bypass/fill half, 1 = butterfly half.
- tw_addr  out  ADDR_W  twiddle ROM address.
- out_valid  out  1  stage output sample valid this cycle.
- frame_start  out  1  high with the first out_valid of each DELAY*2 block.
- busy  out  1  state ≠ IDLE.
- err_ovf  out  1  sticky: write attempted while full.
- err_unf  out  1  sticky: read attempted while empty.

Behaviour:
Reset:
- Synchronous, active-high, highest priority; takes effect mid-operation on any edge.
- State returns to IDLE; cnt=0, half=0, both errors cleared.
- All outputs 0 in the cycle after reset is sampled.
- The FIFOs share areset and are emptied simultaneously.

States:
- IDLE: controller waiting.
  - in_valid → PRIME, and that sample is written.
  - flush is ignored in IDLE.
- PRIME: fills the delay line.
  - fifo_wr = in_valid; fifo_rd = 0; out_valid = 0.
  - cnt increments per valid sample.
  - At cnt = DELAY-1 with in_valid: cnt → 0, go to RUN, half = 1.
- RUN: steady state.
  - Per valid sample: fifo_wr = fifo_rd = 1 in the same cycle, so occupancy stays at DELAY.
  - out_valid = in_valid; bf_sel = half.
  - cnt increments per valid sample; at DELAY-1 it wraps to 0 and half toggles.
  - frame_start = out_valid && cnt = 0 && half = 0.
- Flush in RUN or PRIME: go to FLUSH on the next edge.
  - A simultaneous in_valid sample is still processed that cycle.
- FLUSH: drains the delay line.
  - One output per cycle regardless of in_valid: fifo_rd = 1, fifo_wr = 0, out_valid = 1, bf_sel = 0.
  - cnt counts the entries drained.
  - Leave to IDLE when fifo_empty is sampled high before a read; that read is suppressed and does not set err_unf.

Strobe timing:
- fifo_wr, fifo_rd and out_valid are combinational from the registered state and in_valid (zero-latency, FWFT).
- cnt, half, state and errors are registered.
- Stalls (in_valid = 0) freeze cnt, half and tw_addr.

Twiddle address:
- tw_addr = (cnt*TW_STEP) mod 2^ADDR_W when bf_sel = 1, else 0.
- Computed from the registered cnt; the multiply is a shift-accumulate register updated with cnt (+TW_STEP per step, cleared on wrap).

Error handling:
- In PRIME or RUN, a write with fifo_full = 1 sets err_ovf; a read with fifo_empty = 1 sets err_unf.
- The offending strobe is suppressed (forced 0); the state machine continues.
- Errors clear only on reset.

Optional Feature:
- Macro R2CTRL_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset 0.
  - frame_cnt increments on each frame_start and wraps at 65535 → 0.
- Undefined: port absent; no counter logic.

Test Plan:
- DELAY=4, reset, then 4 valid samples → fifo_wr=1 ×4, fifo_rd=0, out_valid=0; state RUN after the 4th sample.
- Continue with 8 samples → fifo_wr and fifo_rd both 1 ×8; bf_sel=1,1,1,1,0,0,0,0; frame_start on the 5th of the 8; tw_addr=0,1,2,3 then 0 (TW_STEP=1); TW_STEP=2 gives 0,2,4,6.
- RUN with in_valid toggling 1010… → strobes only on valid cycles; cnt and tw_addr hold across gaps.
- Flush pulse after 12 samples, FIFO model holding 4 entries → 4 cycles of fifo_rd=out_valid=1, bf_sel=0, then IDLE with busy=0, err_unf=0.
- Force fifo_full=1 during PRIME → fifo_wr suppressed, err_ovf=1 sticky until reset; force fifo_empty=1 in RUN → err_unf=1.
- Assert areset mid-RUN at cnt=2 → all outputs 0 next cycle, state IDLE; restart primes 4 fresh samples.
- With R2CTRL_FRAME_CNT_EN defined, run 3 full frames → frame_cnt=3.

Source files
------------

// File: rtl/r2sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback FFT stage.
// Drives the delay FIFO strobes, the butterfly select, the twiddle address and
// the output-valid/frame markers, flags FIFO misuse and supports a tail flush.
// Optional feature: define R2CTRL_FRAME_CNT_EN to add the frame_cnt output.
module r2sdf_stage_ctrl #(
   parameter int unsigned DELAY   = 512,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned TW_STEP = 1
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              in_valid,
   input  logic              flush,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic              fifo_wr,
   output logic              fifo_rd,
   output logic              bf_sel,
   output logic [ADDR_W-1:0] tw_addr,
   output logic              out_valid,
   output logic              frame_start,
   output logic              busy,
`ifdef R2CTRL_FRAME_CNT_EN
   output logic [15:0]       frame_cnt,
`endif
   output logic              err_ovf,
   output logic              err_unf
);

   localparam logic [ADDR_W-1:0] CntMax = ADDR_W'(DELAY - 1);
   localparam logic [ADDR_W-1:0] TwStep = ADDR_W'(TW_STEP);
   localparam logic [ADDR_W-1:0] CntOne = ADDR_W'(1);

   typedef enum logic [1:0] {StIdle, StPrime, StRun, StFlush} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] tw_q, tw_d;
   logic              half_q, half_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_unf_q, err_unf_d;
   logic              wr_req, rd_req;

   // Next-state, counter/twiddle accumulator update and strobe decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tw_d        = tw_q;
      half_d      = half_q;
      err_ovf_d   = err_ovf_q;
      err_unf_d   = err_unf_q;
      wr_req      = 1'b0;
      rd_req      = 1'b0;
      fifo_wr     = 1'b0;
      fifo_rd     = 1'b0;
      out_valid   = 1'b0;
      bf_sel      = 1'b0;
      frame_start = 1'b0;

      unique case (state_q)
         StIdle: begin
            // The sample that wakes the controller is the first one primed.
            if (in_valid) begin
               fifo_wr = ~fifo_full;
               cnt_d   = CntOne;
               tw_d    = TwStep;
               half_d  = 1'b0;
               state_d = StPrime;
            end
         end
         StPrime: begin
            wr_req = in_valid;
            if (in_valid) begin
               if (cnt_q == CntMax) begin
                  cnt_d   = '0;
                  tw_d    = '0;
                  half_d  = 1'b1;
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q + CntOne;
                  tw_d  = tw_q + TwStep;
               end
            end
         end
         StRun: begin
            wr_req      = in_valid;
            rd_req      = in_valid;
            out_valid   = in_valid;
            bf_sel      = half_q;
            frame_start = in_valid && (cnt_q == '0) && !half_q;
            if (in_valid) begin
               if (cnt_q == CntMax) begin
                  cnt_d  = '0;
                  tw_d   = '0;
                  half_d = ~half_q;
               end else begin
                  cnt_d = cnt_q + CntOne;
                  tw_d  = tw_q + TwStep;
               end
            end
         end
         StFlush: begin
            // An empty FIFO ends the drain; that read is never issued.
            if (fifo_empty) begin
               cnt_d   = '0;
               tw_d    = '0;
               state_d = StIdle;
            end else begin
               fifo_rd   = 1'b1;
               out_valid = 1'b1;
               cnt_d     = cnt_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase

      // Misuse checks: the offending strobe is dropped, the sequence carries on.
      if (state_q == StPrime || state_q == StRun) begin
         fifo_wr = wr_req && !fifo_full;
         fifo_rd = rd_req && !fifo_empty;
         if (wr_req && fifo_full) err_ovf_d = 1'b1;
         if (rd_req && fifo_empty) err_unf_d = 1'b1;
         // The sample presented with flush is handled above; the drain starts next.
         if (flush) begin
            cnt_d   = '0;
            tw_d    = '0;
            half_d  = 1'b0;
            state_d = StFlush;
         end
      end
   end

   assign tw_addr = bf_sel ? tw_q : '0;
   assign busy    = (state_q != StIdle);
   assign err_ovf = err_ovf_q;
   assign err_unf = err_unf_q;

   // State, counters and sticky error flags.
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         tw_q      <= '0;
         half_q    <= 1'b0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tw_q      <= tw_d;
         half_q    <= half_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

`ifdef R2CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (areset) begin
         frame_cnt_q <= '0;
      end else if (frame_start) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// Directed bench for r2sdf_stage_ctrl with DELAY=4. A second instance uses a
// wider twiddle address and TW_STEP=2 so its stride is visible unwrapped.
module tb_r2sdf_stage_ctrl;

   localparam int unsigned DELAY = 4;
   localparam int NVEC = 38;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic areset, in_valid, flush, fifo_full, fifo_empty;

   logic       a_wr, a_rd, a_bf, a_ov, a_fs, a_busy, a_eo, a_eu;
   logic [1:0] a_tw;
   logic       b_wr, b_rd, b_bf, b_ov, b_fs, b_busy, b_eo, b_eu;
   logic [2:0] b_tw;
`ifdef R2CTRL_FRAME_CNT_EN
   logic [15:0] a_fcnt, b_fcnt;
`endif

   r2sdf_stage_ctrl #(.DELAY(DELAY), .ADDR_W(2), .TW_STEP(1)) u_a (
      .clk(clk), .areset(areset), .in_valid(in_valid), .flush(flush),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_wr(a_wr), .fifo_rd(a_rd), .bf_sel(a_bf), .tw_addr(a_tw),
      .out_valid(a_ov), .frame_start(a_fs), .busy(a_busy),
`ifdef R2CTRL_FRAME_CNT_EN
      .frame_cnt(a_fcnt),
`endif
      .err_ovf(a_eo), .err_unf(a_eu)
   );

   r2sdf_stage_ctrl #(.DELAY(DELAY), .ADDR_W(3), .TW_STEP(2)) u_b (
      .clk(clk), .areset(areset), .in_valid(in_valid), .flush(flush),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_wr(b_wr), .fifo_rd(b_rd), .bf_sel(b_bf), .tw_addr(b_tw),
      .out_valid(b_ov), .frame_start(b_fs), .busy(b_busy),
`ifdef R2CTRL_FRAME_CNT_EN
      .frame_cnt(b_fcnt),
`endif
      .err_ovf(b_eo), .err_unf(b_eu)
   );

   // ins = {in_valid, flush, fifo_full, fifo_empty}
   // outs = {fifo_wr, fifo_rd, out_valid, bf_sel, frame_start, busy, err_ovf, err_unf}
   typedef struct packed {
      logic [3:0] ins;
      logic [7:0] outs;
      logic [1:0] tw;
      logic [2:0] tw2;
   } vec_t;

   vec_t tbl [NVEC];
   int   n_vec = 0;
   int   n_bad = 0;
   int   fs_seen;

   function automatic vec_t mk(input logic [3:0] i, input logic [7:0] o,
                               input logic [1:0] t, input logic [2:0] t2);
      vec_t v;
      v.ins = i; v.outs = o; v.tw = t; v.tw2 = t2;
      return v;
   endfunction

   function automatic logic [7:0] outs_a();
      return {a_wr, a_rd, a_ov, a_bf, a_fs, a_busy, a_eo, a_eu};
   endfunction

   function automatic logic [7:0] outs_b();
      return {b_wr, b_rd, b_ov, b_bf, b_fs, b_busy, b_eo, b_eu};
   endfunction

   task automatic check(input string name, input logic [7:0] eo, input logic [1:0] et,
                        input logic [2:0] et2);
      n_vec++;
      if (outs_a() !== eo || a_tw !== et) begin
         n_bad++;
         $display("FAIL %s inst_a: outs=%b tw=%0d, want outs=%b tw=%0d",
                  name, outs_a(), a_tw, eo, et);
      end
      n_vec++;
      if (outs_b() !== eo || b_tw !== et2) begin
         n_bad++;
         $display("FAIL %s inst_b: outs=%b tw=%0d, want outs=%b tw=%0d",
                  name, outs_b(), b_tw, eo, et2);
      end
   endtask

   // Drive at the falling edge, compare shortly after it.
   task automatic drive(input logic [3:0] i);
      @(negedge clk);
      {in_valid, flush, fifo_full, fifo_empty} = i;
      #1;
   endtask

   task automatic apply_range(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         drive(tbl[k].ins);
         check($sformatf("vec%0d", k), tbl[k].outs, tbl[k].tw, tbl[k].tw2);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      areset = 1'b1;
      {in_valid, flush, fifo_full, fifo_empty} = 4'b0000;
      @(negedge clk);
      areset = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      {in_valid, flush, fifo_full, fifo_empty} = 4'b0000;

      // Reset state, then prime four samples.
      tbl[0]  = mk(4'b0000, 8'b00000000, 2'd0, 3'd0);
      tbl[1]  = mk(4'b1000, 8'b10000000, 2'd0, 3'd0);
      tbl[2]  = mk(4'b1000, 8'b10000100, 2'd0, 3'd0);
      tbl[3]  = mk(4'b1000, 8'b10000100, 2'd0, 3'd0);
      tbl[4]  = mk(4'b1000, 8'b10000100, 2'd0, 3'd0);
      // Run: butterfly half, then bypass half with frame_start on its first sample.
      tbl[5]  = mk(4'b1000, 8'b11110100, 2'd0, 3'd0);
      tbl[6]  = mk(4'b1000, 8'b11110100, 2'd1, 3'd2);
      tbl[7]  = mk(4'b1000, 8'b11110100, 2'd2, 3'd4);
      tbl[8]  = mk(4'b1000, 8'b11110100, 2'd3, 3'd6);
      tbl[9]  = mk(4'b1000, 8'b11101100, 2'd0, 3'd0);
      tbl[10] = mk(4'b1000, 8'b11100100, 2'd0, 3'd0);
      tbl[11] = mk(4'b1000, 8'b11100100, 2'd0, 3'd0);
      tbl[12] = mk(4'b1000, 8'b11100100, 2'd0, 3'd0);
      // Alternating valid: gaps hold the twiddle address.
      tbl[13] = mk(4'b1000, 8'b11110100, 2'd0, 3'd0);
      tbl[14] = mk(4'b0000, 8'b00010100, 2'd1, 3'd2);
      tbl[15] = mk(4'b1000, 8'b11110100, 2'd1, 3'd2);
      tbl[16] = mk(4'b0000, 8'b00010100, 2'd2, 3'd4);
      tbl[17] = mk(4'b1000, 8'b11110100, 2'd2, 3'd4);
      tbl[18] = mk(4'b0000, 8'b00010100, 2'd3, 3'd6);
      // Flush with a sample: that sample still goes through, then 4 drains.
      tbl[19] = mk(4'b1100, 8'b11110100, 2'd3, 3'd6);
      tbl[20] = mk(4'b0000, 8'b01100100, 2'd0, 3'd0);
      tbl[21] = mk(4'b1000, 8'b01100100, 2'd0, 3'd0);
      tbl[22] = mk(4'b0000, 8'b01100100, 2'd0, 3'd0);
      tbl[23] = mk(4'b0000, 8'b01100100, 2'd0, 3'd0);
      tbl[24] = mk(4'b0001, 8'b00000100, 2'd0, 3'd0);
      tbl[25] = mk(4'b0000, 8'b00000000, 2'd0, 3'd0);
      // Overflow while priming, underflow in run; both flags stick.
      tbl[26] = mk(4'b1000, 8'b10000000, 2'd0, 3'd0);
      tbl[27] = mk(4'b1010, 8'b00000100, 2'd0, 3'd0);
      tbl[28] = mk(4'b1000, 8'b10000110, 2'd0, 3'd0);
      tbl[29] = mk(4'b1000, 8'b10000110, 2'd0, 3'd0);
      tbl[30] = mk(4'b1001, 8'b10110110, 2'd0, 3'd0);
      tbl[31] = mk(4'b1000, 8'b11110111, 2'd1, 3'd2);
      tbl[32] = mk(4'b0000, 8'b00010111, 2'd2, 3'd4);
      // After a mid-run reset: fresh prime and first run sample.
      tbl[33] = mk(4'b1000, 8'b10000000, 2'd0, 3'd0);
      tbl[34] = mk(4'b1000, 8'b10000100, 2'd0, 3'd0);
      tbl[35] = mk(4'b1000, 8'b10000100, 2'd0, 3'd0);
      tbl[36] = mk(4'b1000, 8'b10000100, 2'd0, 3'd0);
      tbl[37] = mk(4'b1000, 8'b11110100, 2'd0, 3'd0);

      repeat (2) @(negedge clk);
      areset = 1'b0;

      apply_range(0, 32);

      // Mid-run reset at cnt=2 with both error flags set.
      do_reset();
      #1;
      check("reset_midrun", 8'b00000000, 2'd0, 3'd0);

      apply_range(33, 37);

      // Three full frames after a clean reset.
      do_reset();
      fs_seen = 0;
      for (int k = 0; k < 4 + 3 * 2 * DELAY; k++) begin
         drive(4'b1000);
         if (a_fs) fs_seen++;
      end
      n_vec++;
      if (fs_seen != 3) begin
         n_bad++;
         $display("FAIL frame_starts: got %0d, want 3", fs_seen);
      end
`ifdef R2CTRL_FRAME_CNT_EN
      drive(4'b0000);
      n_vec++;
      if (a_fcnt !== 16'd3 || b_fcnt !== 16'd3) begin
         n_bad++;
         $display("FAIL frame_cnt: got %0d/%0d, want 3", a_fcnt, b_fcnt);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
